multicycle_control: RTL and testbench

- Multi-cycle MIPS main controller FSM. It replaces the single-cycle opcode decoder when the datapath is shared across cycles.
- Sequences one shared ALU, one unified instruction/data memory port, the IR, the PC and the register file through fetch/decode/execute/memory/writeback.
- Sits between the opcode field of the IR and the datapath muxes/enables. It also handles a memory ready handshake with a stall timeout.

---
 rtl/multicycle_control.sv | 260 ++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Multi-cycle MIPS main controller. Sequences a shared ALU, a
//             unified instruction/data memory port, the IR, the PC and the
//             register file through fetch/decode/execute/memory/writeback.
//             It also handles the memory ready handshake with a stall timeout.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT_CYCLES : mem_ready-low cycles tolerated in a memory state
//                     (0 = never abort)
//    CNT_W          : wait counter width, 2**CNT_W > TIMEOUT_CYCLES
//  Ports
//    clk, rst       : clock (rising edge), asynchronous active-high reset
//    instruction    : opcode IR[31:26], sampled only in DECODE
//    mem_ready      : memory completes the current access this cycle
//    PCWrite .. PCSource : datapath enables and mux selects
//    state          : current state encoding (debug)
//    instr_done     : final cycle of an instruction
//    illegal_op     : one-cycle pulse after an unsupported opcode
//    mem_timeout    : one-cycle pulse after a stall abort
//  Build option
//    ADDI_EN        : when defined, opcode 001000 (addi) is supported;
//                     otherwise it is treated as illegal
// ============================================================================
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] instruction,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
`ifdef ADDI_EN
        ,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
`endif
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
`ifdef ADDI_EN
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
`endif
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         opcode_q, opcode_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;
    logic               w_wait_state;
    logic               w_expire;

    // ------------------------------------------------------------------
    // State and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // States that wait on the memory handshake
    assign w_wait_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                          (state_q == S_MEM_WRITE);

    // Abort fires on the last tolerated low cycle; a same-cycle mem_ready wins
    // because the term requires mem_ready low.
    assign w_expire = (TIMEOUT_CYCLES != 0) && w_wait_state && !mem_ready &&
                      (cnt_q == c_CNT_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        opcode_d  = opcode_q;
        illegal_d = 1'b0;
        timeout_d = 1'b0;

        // Counter saturates so a disabled timeout never wraps back to zero
        if (w_wait_state && !mem_ready && !w_expire && (cnt_q != c_CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (w_wait_state && !mem_ready && !w_expire) begin
            cnt_d = cnt_q;
        end

        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                opcode_d = instruction;
                case (instruction)
                    c_OP_RTYPE:        state_d = S_EXECUTE;
                    c_OP_LW, c_OP_SW:  state_d = S_MEM_ADDR;
                    c_OP_BEQ:          state_d = S_BRANCH;
                    c_OP_J:            state_d = S_JUMP;
`ifdef ADDI_EN
                    c_OP_ADDI:         state_d = S_ADDI_EX;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            // lw/sw choice uses the opcode captured in DECODE, not the live input
            S_MEM_ADDR:  state_d = (opcode_q == c_OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTE:   state_d = S_R_WB;
`ifdef ADDI_EN
            S_ADDI_EX:   state_d = S_ADDI_WB;
`endif
            default:     state_d = S_FETCH;
        endcase

        if (w_expire) begin
            state_d   = S_FETCH;
            timeout_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (Moore, except FETCH/MEM_WRITE handshake terms)
    // ------------------------------------------------------------------
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;

        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE:   ALUSrcB = 2'b11;
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite   = 1'b1;
                    MemToReg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WRITE: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_R_WB: begin
                    RegDst     = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    instr_done  = 1'b1;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    instr_done = 1'b1;
                end
`ifdef ADDI_EN
                S_ADDI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_ADDI_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign state       = rst ? 4'd0 : state_q;
    assign illegal_op  = illegal_q & ~rst;
    assign mem_timeout = timeout_q & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_multicycle_control
//  Purpose  : Self-checking bench for multicycle_control. A generator expands
//             each instruction into its per-cycle input schedule and expected
//             observation; a monitor compares the DUT every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    localparam int TMO = 15;

    // State numbers as published for the debug port
    localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                           MWR = 4'd5, EX = 4'd6, RWB = 4'd7, BR = 4'd8, JP = 4'd9,
                           AE = 4'd10, AW = 4'd11;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] instruction;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemToReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic       instr_done, illegal_op, mem_timeout;

    multicycle_control #(.TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .state(state), .instr_done(instr_done), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] instr;
        logic       rdy;
    } stim_t;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, pcs;
        logic       done, ill, tmo;
    } obs_t;

    stim_t in_q[$];
    obs_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc_no = 0;
    bit    mon_en = 1'b0;
    bit    pend_ill = 1'b0;
    bit    pend_tmo = 1'b0;

    function automatic obs_t actual();
        obs_t a;
        a = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done,
             illegal_op, mem_timeout};
        return a;
    endfunction

    // Control word each state must present, straight from the state table
    function automatic obs_t spec_out(input logic [3:0] st, input logic rdy);
        obs_t o;
        o    = '0;
        o.st = st;
        case (st)
            FE:  begin o.mr = 1; o.asb = 2'b01; o.irw = rdy; o.pcw = rdy; end
            DE:  o.asb = 2'b11;
            MA:  begin o.asa = 1; o.asb = 2'b10; end
            MR:  begin o.mr = 1; o.iord = 1; end
            MWB: begin o.rw = 1; o.m2r = 1; o.done = 1; end
            MWR: begin o.mw = 1; o.iord = 1; o.done = rdy; end
            EX:  begin o.asa = 1; o.aop = 2'b10; end
            RWB: begin o.rdst = 1; o.rw = 1; o.done = 1; end
            BR:  begin o.asa = 1; o.aop = 2'b01; o.pcwc = 1; o.pcs = 2'b01; o.done = 1; end
            JP:  begin o.pcw = 1; o.pcs = 2'b10; o.done = 1; end
            AE:  begin o.asa = 1; o.asb = 2'b10; end
            AW:  begin o.rw = 1; o.done = 1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        bit l;
        l = (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
`ifdef ADDI_EN
        l = l || (op == OP_ADDI);
`endif
        return l;
    endfunction

    // One cycle: inputs to drive and what the DUT must show in that cycle
    task automatic cyc(input logic [3:0] st, input logic rdy, input logic [5:0] ins);
        stim_t s;
        obs_t  e;
        s.instr = ins;
        s.rdy   = rdy;
        in_q.push_back(s);
        e     = spec_out(st, rdy);
        e.ill = pend_ill;
        e.tmo = pend_tmo;
        pend_ill = 1'b0;
        pend_tmo = 1'b0;
        exp_q.push_back(e);
    endtask

    // Memory access with w stall cycles; w >= TMO means the memory never answers
    task automatic mem_phase(input logic [3:0] st, input int w, output bit aborted);
        aborted = 1'b0;
        if (w >= TMO) begin
            for (int i = 0; i < TMO; i++) cyc(st, 1'b0, rnd6());
            pend_tmo = 1'b1;
            aborted  = 1'b1;
        end else begin
            for (int i = 0; i < w; i++) cyc(st, 1'b0, rnd6());
            cyc(st, 1'b1, rnd6());
        end
    endtask

    task automatic gen_instr(input logic [5:0] op, input int fw, input int mw);
        bit ab;
        mem_phase(FE, fw, ab);
        if (ab) return;
        cyc(DE, 1'($urandom), op);
        if (op == OP_R) begin
            cyc(EX, 1'($urandom), rnd6());
            cyc(RWB, 1'($urandom), rnd6());
        end else if (op == OP_LW) begin
            cyc(MA, 1'($urandom), rnd6());
            mem_phase(MR, mw, ab);
            if (!ab) cyc(MWB, 1'($urandom), rnd6());
        end else if (op == OP_SW) begin
            cyc(MA, 1'($urandom), rnd6());
            mem_phase(MWR, mw, ab);
        end else if (op == OP_BEQ) begin
            cyc(BR, 1'($urandom), rnd6());
        end else if (op == OP_J) begin
            cyc(JP, 1'($urandom), rnd6());
`ifdef ADDI_EN
        end else if (op == OP_ADDI) begin
            cyc(AE, 1'($urandom), rnd6());
            cyc(AW, 1'($urandom), rnd6());
`endif
        end else begin
            pend_ill = 1'b1;
        end
    endtask

    function automatic int rnd_wait();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 12) return 0;
        if (r < 16) return int'($urandom_range(1, 3));
        if (r < 18) return TMO - 1;
        if (r == 18) return TMO;
        return 2;
    endfunction

    // Called at posedge+1; drives one scheduled cycle per clock
    task automatic run_cycles(input int n);
        stim_t s;
        for (int i = 0; i < n && in_q.size() > 0; i++) begin
            s = in_q.pop_front();
            instruction = s.instr;
            mem_ready   = s.rdy;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string name);
        obs_t a;
        a = actual();
        checks++;
        if (a !== '0) begin
            errors++;
            $display("FAIL %s: outputs during reset got %h required 0", name, a);
        end
    endtask

    // Monitor: one comparison per enabled cycle
    initial begin
        obs_t a, e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                a = actual();
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty cycle %0d: got %h", cyc_no, a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL cycle_obs cycle %0d: got state %0d word %h required state %0d word %h",
                                 cyc_no, a.st, a, e.st, e);
                    end
                end
                cyc_no++;
            end
        end
    end

    initial begin
        logic [5:0] op;
        rst = 1'b0;
        instruction = OP_R;
        mem_ready = 1'b1;
        #2 rst = 1'b1;           // mid-cycle, before any clock edge
        #1 check_zero("reset_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            instruction = rnd6();
            check_zero("reset_hold");
        end
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Directed scenarios
        gen_instr(OP_R, 0, 0);
        gen_instr(OP_LW, 0, 2);
        gen_instr(OP_SW, 0, 0);
        gen_instr(OP_BEQ, 0, 0);
        gen_instr(OP_J, 0, 0);
        gen_instr(6'b010101, 0, 0);
        gen_instr(OP_R, TMO, 0);        // fetch stall abort
        gen_instr(OP_R, TMO - 1, 0);    // ready on last tolerated cycle
        gen_instr(OP_LW, 0, TMO);       // read stall abort
        gen_instr(OP_SW, 1, TMO - 1);
        gen_instr(OP_ADDI, 0, 0);
        gen_instr(OP_R, 0, 0);
        run_cycles(in_q.size());

        // Randomized program
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 6))
                0: op = OP_R;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_J;
                5: op = OP_ADDI;
                default: begin
                    op = rnd6();
                    while (is_legal(op)) op = rnd6();
                end
            endcase
            gen_instr(op, rnd_wait(), rnd_wait());
        end
        gen_instr(OP_R, 0, 0);
        run_cycles(in_q.size());

        // Reset in the middle of a lw memory stall
        gen_instr(OP_LW, 0, 3);
        run_cycles(4);
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        mem_ready = 1'b1;
        #1 check_zero("reset_mid_instr");
        in_q.delete();
        exp_q.delete();
        pend_ill = 1'b0;
        pend_tmo = 1'b0;
        @(negedge clk);
        check_zero("reset_mid_hold");
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        gen_instr(OP_R, 0, 0);
        gen_instr(OP_LW, 1, 0);
        gen_instr(OP_R, 0, 0);
        run_cycles(in_q.size());

        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
